// File: rtl/fir_channel_scheduler.sv
`default_nettype none
// ============================================================================
// fir_channel_scheduler : round-robin arbiter feeding a shared serial FIR engine
// Revision: 1.0 - initial release
// ============================================================================
module fir_channel_scheduler #(
    parameter  int WIDTH   = 16,
    parameter  int NUM_CH  = 4,
    parameter  int TIMEOUT = 64,
    localparam int CH_W    = $clog2(NUM_CH)
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic [NUM_CH*WIDTH-1:0] ch_sample_in,
    input  logic [NUM_CH-1:0]       ch_valid_in,
    output logic signed [WIDTH-1:0] filt_audio_out,
    output logic                    filt_valid_out,
    input  logic signed [WIDTH-1:0] filt_audio_in,
    input  logic                    filt_ready_in,
    output logic signed [WIDTH-1:0] result_out,
    output logic [CH_W-1:0]         result_ch_out,
    output logic                    result_valid_out,
    output logic                    busy_out,
    output logic [NUM_CH-1:0]       overrun_out,
    output logic                    timeout_err_out,
    input  logic                    clear_err_in
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  c_wait_last = CNT_W'(TIMEOUT - 1);
    localparam logic [NUM_CH-1:0] c_one_hot0  = NUM_CH'(1);
    localparam logic [CH_W-1:0]   c_last_rst  = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic signed [WIDTH-1:0] w_ch_sample [NUM_CH];
    logic signed [WIDTH-1:0] r_hold      [NUM_CH];
    logic [NUM_CH-1:0]       r_pending;
    logic [NUM_CH-1:0]       r_overrun;
    logic [NUM_CH-1:0]       w_grant_vec;
    logic [NUM_CH-1:0]       w_overrun_set;
    logic [CH_W-1:0]         r_last_grant;
    logic [CH_W-1:0]         w_win;
    logic                    w_found;
    logic                    w_grant_fire;
    logic                    w_wait_timeout;
    logic [CNT_W-1:0]        r_wait_cnt;
    logic                    r_timeout_err;
    int                      w_idx;

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_unpack
            assign w_ch_sample[k] = ch_sample_in[k*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin search starting just above the most recently granted channel.
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_idx = int'(r_last_grant) + 1 + i;
            if (w_idx >= NUM_CH) begin
                w_idx = w_idx - NUM_CH;
            end
            if (!w_found && r_pending[CH_W'(w_idx)]) begin
                w_win   = CH_W'(w_idx);
                w_found = 1'b1;
            end
        end
    end

    assign w_grant_fire  = (r_state == IDLE) && (|r_pending);
    assign w_grant_vec   = w_grant_fire ? (c_one_hot0 << w_win) : '0;
    // A re-strobe on the channel being granted is a fresh sample, not an overrun.
    assign w_overrun_set = ch_valid_in & r_pending & ~w_grant_vec;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_hold[i] <= '0;
            end
            r_pending <= '0;
            r_overrun <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_valid_in[i]) begin
                    r_hold[i] <= w_ch_sample[i];
                end
            end
            r_pending <= (r_pending & ~w_grant_vec) | ch_valid_in;
            r_overrun <= (r_overrun & ~{NUM_CH{clear_err_in}}) | w_overrun_set;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        filt_valid_out   = 1'b0;
        result_valid_out = 1'b0;
        w_wait_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (|r_pending) begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                filt_valid_out = 1'b1;
                w_state_next   = WAIT;
            end
            WAIT: begin
                if (filt_ready_in) begin
                    w_state_next = DONE;
                end else if (r_wait_cnt == c_wait_last) begin
                    w_wait_timeout = 1'b1;
                    w_state_next   = IDLE;
                end
            end
            DONE: begin
                result_valid_out = 1'b1;
                w_state_next     = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            filt_audio_out <= '0;
            r_last_grant   <= c_last_rst;
            r_wait_cnt     <= '0;
            result_out     <= '0;
            result_ch_out  <= '0;
            r_timeout_err  <= 1'b0;
        end else begin
            if (w_grant_fire) begin
                filt_audio_out <= r_hold[w_win];
                r_last_grant   <= w_win;
            end
            if (r_state == ISSUE) begin
                r_wait_cnt <= '0;
            end else if ((r_state == WAIT) && !filt_ready_in) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if ((r_state == WAIT) && filt_ready_in) begin
                result_out    <= filt_audio_in;
                result_ch_out <= r_last_grant;
            end
            r_timeout_err <= (r_timeout_err & ~clear_err_in) | w_wait_timeout;
        end
    end

    assign busy_out        = (r_state != IDLE);
    assign overrun_out     = r_overrun;
    assign timeout_err_out = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_fir_channel_scheduler.sv
`default_nettype none
// ============================================================================
// tb_fir_channel_scheduler : directed scoreboard bench with a behavioural engine
// Revision: 1.0 - initial release
// ============================================================================
module tb_fir_channel_scheduler;

    localparam int WIDTH   = 16;
    localparam int NUM_CH  = 4;
    localparam int TIMEOUT = 64;
    localparam int CH_W    = 2;

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [WIDTH-1:0] data;
    } res_t;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_CH*WIDTH-1:0] ch_sample;
    logic [NUM_CH-1:0]       ch_valid;
    logic [WIDTH-1:0]        filt_audio_out;
    logic                    filt_valid_out;
    logic [WIDTH-1:0]        filt_audio_in;
    logic                    filt_ready_in;
    logic [WIDTH-1:0]        result_out;
    logic [CH_W-1:0]         result_ch_out;
    logic                    result_valid_out;
    logic                    busy_out;
    logic [NUM_CH-1:0]       overrun_out;
    logic                    timeout_err_out;
    logic                    clear_err;

    logic [WIDTH-1:0]        exp_issue [$];
    res_t                    exp_res   [$];
    logic [WIDTH-1:0]        mon_issue;
    res_t                    mon_res;
    logic signed [WIDTH-1:0] eng_data;
    int                      eng_lat;
    logic                    eng_on;
    int                      cyc = 0;
    int                      n_checks = 0;
    int                      n_fail = 0;
    int                      t0;
    int                      wk;

    fir_channel_scheduler #(
        .WIDTH   (WIDTH),
        .NUM_CH  (NUM_CH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .ch_sample_in     (ch_sample),
        .ch_valid_in      (ch_valid),
        .filt_audio_out   (filt_audio_out),
        .filt_valid_out   (filt_valid_out),
        .filt_audio_in    (filt_audio_in),
        .filt_ready_in    (filt_ready_in),
        .result_out       (result_out),
        .result_ch_out    (result_ch_out),
        .result_valid_out (result_valid_out),
        .busy_out         (busy_out),
        .overrun_out      (overrun_out),
        .timeout_err_out  (timeout_err_out),
        .clear_err_in     (clear_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every engine start and every result is matched against the queues.
    always @(negedge clk) begin
        if (rst_n && filt_valid_out) begin
            if (exp_issue.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_issue: got 0x%0h expected none", filt_audio_out);
            end else begin
                mon_issue = exp_issue.pop_front();
                check("issue_data", {16'h0, filt_audio_out}, {16'h0, mon_issue});
            end
        end
        if (rst_n && result_valid_out) begin
            if (exp_res.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got ch%0d 0x%0h expected none",
                         result_ch_out, result_out);
            end else begin
                mon_res = exp_res.pop_front();
                check("result_data", {16'h0, result_out}, {16'h0, mon_res.data});
                check("result_ch", {30'h0, result_ch_out}, {30'h0, mon_res.ch});
            end
        end
    end

    // Engine model: returns the sample arithmetically halved, eng_lat cycles later.
    initial begin
        filt_ready_in = 1'b0;
        filt_audio_in = '0;
        forever begin
            @(negedge clk);
            if (rst_n && filt_valid_out && eng_on) begin
                eng_data = filt_audio_out;
                repeat (eng_lat) @(posedge clk);
                #1;
                filt_audio_in = eng_data >>> 1;
                filt_ready_in = 1'b1;
                @(posedge clk);
                #1;
                filt_ready_in = 1'b0;
            end
        end
    end

    initial begin
        repeat (30000) @(posedge clk);
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "bench watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [NUM_CH-1:0] mask, input logic [NUM_CH*WIDTH-1:0] s);
        ch_sample = s;
        ch_valid  = mask;
        @(posedge clk);
        #1;
        ch_valid  = '0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        ch_valid  = '0;
        clear_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((exp_issue.size() != 0 || exp_res.size() != 0 || busy_out) && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_checks++;
        if (k >= 300) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d cycles pending expected under 300", name, k);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        ch_valid  = '0;
        ch_sample = '0;
        clear_err = 1'b0;
        eng_on    = 1'b1;
        eng_lat   = 3;
        repeat (3) @(posedge clk);
        #1;
        check("reset_flags", {27'h0, busy_out, filt_valid_out, result_valid_out, timeout_err_out, 1'b0},
              32'h0);
        check("reset_overrun", {28'h0, overrun_out}, 32'h0);
        check("reset_data", {result_out, filt_audio_out}, 32'h0);
        check("reset_ch", {30'h0, result_ch_out}, 32'h0);
        rst_n = 1'b1;
        tick(1);

        // Single channel, slow engine
        eng_lat = 30;
        exp_issue.push_back(16'h0100);
        exp_res.push_back(res_t'({2'd1, 16'h0080}));
        strobe(4'b0010, {16'h0, 16'h0, 16'h0100, 16'h0});
        drain("t1");
        tick(3);
        check("t1_result_hold", {16'h0, result_out}, 32'h0080);

        // All channels together, then a second round that must restart at ch0
        do_reset();
        eng_lat = 3;
        exp_issue.push_back(16'h0010);
        exp_issue.push_back(16'h0020);
        exp_issue.push_back(16'h0040);
        exp_issue.push_back(16'hFF80);
        exp_res.push_back(res_t'({2'd0, 16'h0008}));
        exp_res.push_back(res_t'({2'd1, 16'h0010}));
        exp_res.push_back(res_t'({2'd2, 16'h0020}));
        exp_res.push_back(res_t'({2'd3, 16'hFFC0}));
        strobe(4'b1111, {16'hFF80, 16'h0040, 16'h0020, 16'h0010});
        drain("t2a");
        exp_issue.push_back(16'h0200);
        exp_issue.push_back(16'h0300);
        exp_res.push_back(res_t'({2'd0, 16'h0100}));
        exp_res.push_back(res_t'({2'd2, 16'h0180}));
        strobe(4'b0101, {16'h0, 16'h0300, 16'h0, 16'h0200});
        drain("t2b");
        check("t2_overrun", {28'h0, overrun_out}, 32'h0);

        // Overrun on ch2 while ch0 is in service; clear racing a new ch3 overrun
        do_reset();
        eng_lat = 20;
        exp_issue.push_back(16'h0400);
        exp_issue.push_back(16'h0022);
        exp_issue.push_back(16'h0044);
        exp_res.push_back(res_t'({2'd0, 16'h0200}));
        exp_res.push_back(res_t'({2'd2, 16'h0011}));
        exp_res.push_back(res_t'({2'd3, 16'h0022}));
        strobe(4'b0001, {16'h0, 16'h0, 16'h0, 16'h0400});
        tick(2);
        strobe(4'b0100, {16'h0, 16'h0011, 16'h0, 16'h0});
        strobe(4'b0100, {16'h0, 16'h0022, 16'h0, 16'h0});
        check("t3_overrun_set", {28'h0, overrun_out}, 32'h4);
        check("t3_busy", {31'h0, busy_out}, 32'h1);
        strobe(4'b1000, {16'h0033, 16'h0, 16'h0, 16'h0});
        clear_err = 1'b1;
        strobe(4'b1000, {16'h0044, 16'h0, 16'h0, 16'h0});
        clear_err = 1'b0;
        check("t3_clear_vs_set", {28'h0, overrun_out}, 32'h8);
        drain("t3");
        check("t3_sticky", {28'h0, overrun_out}, 32'h8);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        check("t3_cleared", {28'h0, overrun_out}, 32'h0);

        // Engine silent on ch0: timeout after 64 WAIT cycles, then ch1 proceeds
        do_reset();
        eng_on  = 1'b0;
        eng_lat = 3;
        exp_issue.push_back(16'h0500);
        exp_issue.push_back(16'h0600);
        exp_res.push_back(res_t'({2'd1, 16'h0300}));
        strobe(4'b0011, {16'h0, 16'h0, 16'h0600, 16'h0500});
        wk = 0;
        while (!filt_valid_out && wk < 50) begin
            @(negedge clk);
            wk++;
        end
        check("t4_first_issue", {31'h0, filt_valid_out}, 32'h1);
        t0 = cyc;
        @(posedge clk);
        #1;
        eng_on = 1'b1;
        wk = 0;
        @(negedge clk);
        while (!filt_valid_out && wk < 200) begin
            @(negedge clk);
            wk++;
        end
        check("t4_timeout_gap", cyc - t0, 32'd66);
        check("t4_timeout_flag", {31'h0, timeout_err_out}, 32'h1);
        drain("t4");
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        check("t4_timeout_clear", {31'h0, timeout_err_out}, 32'h0);

        // Asynchronous reset in WAIT, engine answers after release
        do_reset();
        eng_lat = 10;
        exp_issue.push_back(16'h0700);
        strobe(4'b1000, {16'h0700, 16'h0, 16'h0, 16'h0});
        tick(5);
        check("t5_in_wait", {31'h0, busy_out}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_flags", {29'h0, busy_out, filt_valid_out, result_valid_out}, 32'h0);
        check("t5_async_data", {16'h0, filt_audio_out}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(20);
        check("t5_no_result", {16'h0, result_out}, 32'h0);
        check("t5_queue", exp_issue.size(), 32'h0);

        // Ch0 re-strobed in its own grant cycle alongside a new ch1 request
        do_reset();
        eng_lat = 5;
        exp_issue.push_back(16'h0800);
        exp_issue.push_back(16'h0A00);
        exp_issue.push_back(16'h0900);
        exp_res.push_back(res_t'({2'd0, 16'h0400}));
        exp_res.push_back(res_t'({2'd1, 16'h0500}));
        exp_res.push_back(res_t'({2'd0, 16'h0480}));
        strobe(4'b0001, {16'h0, 16'h0, 16'h0, 16'h0800});
        strobe(4'b0011, {16'h0, 16'h0, 16'h0A00, 16'h0900});
        check("t6_no_overrun", {28'h0, overrun_out}, 32'h0);
        drain("t6");
        check("t6_no_overrun_end", {28'h0, overrun_out}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_channel_scheduler.md
FIR_CHANNEL_SCHEDULER -- requirements
Module: fir_channel_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the sample width in bits.
REQ-002 SHALL have parameter NUM_CH, default 4, the number of requesting audio channels (2..8).
REQ-003 SHALL have parameter TIMEOUT, default 64, the maximum cycles to wait for the engine result.
REQ-004 SHALL have a localparam CH_W = $clog2(NUM_CH).
REQ-005 clk_in  input  1  the single clock; all logic is on the rising edge.
REQ-006 rst_n_in  input  1  reset, asynchronous and active-low.
REQ-007 ch_sample_in  input  NUM_CH*WIDTH  signed samples; channel k is in bits [k*WIDTH +: WIDTH].
REQ-008 ch_valid_in  input  NUM_CH  per-channel one-cycle sample strobe.
REQ-009 filt_audio_out  output  WIDTH  signed sample to the shared serial FIR engine.
REQ-010 filt_valid_out  output  1  one-cycle start strobe to the engine.
REQ-011 filt_audio_in  input  WIDTH  signed filtered result from the engine.
REQ-012 filt_ready_in  input  1  one-cycle result strobe from the engine.
REQ-013 result_out  output  WIDTH  signed filtered sample.
REQ-014 result_ch_out  output  CH_W  channel index of result_out.
REQ-015 result_valid_out  output  1  one-cycle result strobe.
REQ-016 busy_out  output  1  high when the FSM is not in IDLE.
REQ-017 overrun_out  output  NUM_CH  sticky per-channel overrun flags.
REQ-018 timeout_err_out  output  1  sticky engine-timeout flag.
REQ-019 clear_err_in  input  1  synchronous clear for overrun_out and timeout_err_out.

Function
REQ-020 SHALL keep one holding register and one pending bit per channel; ch_valid_in[k] SHALL load sample k and set pending[k] on the next edge.
REQ-021 If ch_valid_in[k] arrives while pending[k] is set and channel k is not being granted that cycle, the new sample SHALL overwrite the old one and overrun_out[k] SHALL set.
REQ-022 If ch_valid_in[k] arrives in the same cycle channel k is granted, the new sample SHALL be captured, pending[k] SHALL remain set, and no overrun SHALL be flagged.
REQ-023 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE.
REQ-024 IDLE: when any pending bit is set, the FSM SHALL grant the round-robin winner, copy its sample to filt_audio_out, clear its pending bit, and go to ISSUE.
REQ-025 The round-robin winner SHALL be the first pending channel searching upward from (last_grant+1) mod NUM_CH; last_grant SHALL reset to NUM_CH-1 so that channel 0 wins first.
REQ-026 ISSUE: filt_valid_out SHALL be high for exactly this one cycle, then the FSM SHALL go to WAIT with the wait counter at 0.
REQ-027 WAIT: on filt_ready_in the FSM SHALL register filt_audio_in into result_out and the granted index into result_ch_out, and go to DONE.
REQ-028 WAIT: otherwise the counter SHALL increment; when it reaches TIMEOUT-1 without filt_ready_in, the FSM SHALL set timeout_err_out, drop the sample, and go to IDLE.
REQ-029 DONE: result_valid_out SHALL be high for exactly this one cycle, then the FSM SHALL go to IDLE.
REQ-030 filt_ready_in outside WAIT SHALL be ignored.
REQ-031 filt_audio_out and result_out SHALL hold their values until next overwritten.
REQ-032 clear_err_in SHALL clear all flags, but a new set event in the same cycle SHALL win.
REQ-033 Minimum latency from ch_valid_in to result_valid_out SHALL be engine latency + 4 cycles.

Reset
REQ-034 While rst_n_in is low, the FSM SHALL be in IDLE and all pending bits, flags, strobes, result_out, result_ch_out and filt_audio_out SHALL be 0.
REQ-035 Reset asserted mid-transaction SHALL abort it immediately, with no result_valid_out emitted after release.
REQ-036 After release, operation SHALL resume on the first rising edge with rst_n_in high.

Verification
REQ-037 Ch1 sample 0x0100, engine returns 0x0080 after 30 cycles -> one filt_valid_out pulse carrying 0x0100; result_valid_out with result_out=0x0080 and result_ch_out=1.
REQ-038 All 4 channels strobed in the same cycle -> grants issue in order 0,1,2,3, then the next round starts at 0; each channel gets exactly one result.
REQ-039 Ch2 strobed twice (0x0011, then 0x0022) while ch0 is in service -> overrun_out[2]=1 and 0x0022 is issued; clear_err_in then clears overrun_out[2].
REQ-040 Engine never returns filt_ready_in -> after 64 WAIT cycles timeout_err_out=1, no result_valid_out, and the next pending channel is issued.
REQ-041 rst_n_in pulled low during WAIT -> outputs are 0 asynchronously, and a late filt_ready_in after release produces no result.
REQ-042 Ch0 re-strobed in its own grant cycle -> no overrun, and ch0 is serviced again on its next round-robin turn.
